// File: rtl/fft_sp_pingpong.sv
// Serial-to-parallel FFT input stage: collects NPTS complex samples per frame into one of two
// ping-pong banks and presents a full frame as a wide parallel word with valid/ready handshakes.
module fft_sp_pingpong #(
  parameter int unsigned DW    = 34,
  parameter int unsigned NPTS  = 16,
  parameter int unsigned LOG2N = 4,
  parameter int unsigned ECW   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DW-1:0]        in_data_i,
  input  logic                 in_last_i,
  input  logic                 bitrev_en_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NPTS*DW-1:0]   out_data_o,
  output logic                 out_bitrev_o,
  output logic                 frame_err_o,
  output logic [ECW-1:0]       err_cnt_o
);

  localparam int unsigned FW = NPTS * DW;
  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(NPTS - 1);

  logic [1:0][FW-1:0] bank_q, bank_d;
  logic [1:0]         full_q, full_d;
  logic [1:0]         mode_q, mode_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic               frame_err_q, frame_err_d;
  logic [ECW-1:0]     err_cnt_q, err_cnt_d;

  logic             in_fire, out_fire, use_rev, err_now;
  logic [LOG2N-1:0] wr_idx;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready_o   = ~full_q[wr_ptr_q];
  assign in_fire      = in_valid_i & in_ready_o;
  assign out_valid_o  = full_q[rd_ptr_q];
  assign out_fire     = out_valid_o & out_ready_i;
  assign out_data_o   = bank_q[rd_ptr_q];
  assign out_bitrev_o = mode_q[rd_ptr_q];
  assign frame_err_o  = frame_err_q;
  assign err_cnt_o    = err_cnt_q;

  // The first sample of a frame uses the live mode input; later samples use the latched mode.
  assign use_rev = (cnt_q == '0) ? bitrev_en_i : mode_q[wr_ptr_q];
  assign wr_idx  = use_rev ? bit_rev(cnt_q) : cnt_q;

  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
    err_now     = 1'b0;

    if (out_fire) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end

    if (in_fire) begin
      bank_d[wr_ptr_q][int'(wr_idx)*DW +: DW] = in_data_i;
      if (cnt_q == '0) begin
        mode_d[wr_ptr_q] = bitrev_en_i;
      end
      if (cnt_q == LastIdx) begin
        // Length is right by construction, so the frame is kept even without in_last.
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        cnt_d            = '0;
        err_now          = ~in_last_i;
      end else if (in_last_i) begin
        cnt_d   = '0;
        err_now = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    frame_err_d = err_now;
    if (err_now && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q      <= '0;
      full_q      <= '0;
      mode_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bank_q      <= bank_d;
      full_q      <= full_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: doc/fft_sp_pingpong.md
Name: fft_sp_pingpong

Overview:
- Parametrised successor to the FFT serial-to-parallel stage.
- Collects NPTS serial complex samples into a full frame and presents the frame as one wide parallel word to the butterfly array.
- Two register banks (ping-pong) allow one frame to fill while the previous frame is held for the consumer.
- Adds valid/ready handshakes on both sides, optional bit-reversed write ordering, and frame-length checking.

Parameters:
- DW, 34: sample width; [DW-1:DW/2] = real part, [DW/2-1:0] = imaginary part; must be even.
- NPTS, 16: points per frame; power of two, 2..64.
- LOG2N, 4: log2(NPTS); index width.
- ECW, 8: width of the error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  serial sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  DW  serial complex sample.
- in_last  input  1  marks the final sample of a frame.
- bitrev_en  input  1  write order select: 1 = bit-reversed index, 0 = natural index.
- out_valid  output  1  a complete frame is presented.
- out_ready  input  1  consumer accepts the frame.
- out_data  output  NPTS*DW  frame; slot k occupies [k*DW +: DW].
- out_bitrev  output  1  ordering mode of the presented frame.
- frame_err  output  1  one-cycle pulse on a framing error.
- err_cnt  output  ECW  saturating count of framing errors.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both banks, the full flags, the write/read bank pointers and the sample counter go to 0.
  - out_valid=0, out_data=0, out_bitrev=0, frame_err=0, err_cnt=0.
  - in_ready=1 once reset is released. Sources must not assert in_valid while rst_n is low.
- Reset mid-frame or mid-handshake discards all buffered data. No partial frame survives reset.
- State per bank: EMPTY -> FILLING -> FULL -> EMPTY.
  - wr_ptr selects the filling bank; rd_ptr selects the presented bank.
- Input acceptance:
  - in_ready = !full[wr_ptr], combinational.
  - A sample is accepted when in_valid && in_ready on a rising edge.
- On acceptance with counter value cnt:
  - When cnt==0, latch bitrev_en as the frame's mode.
  - Write to slot idx: idx = cnt (natural mode) or idx = bit-reverse of cnt over LOG2N bits (reversed mode).
  - Increment cnt.
- Frame completion, when the accepted sample has cnt==NPTS-1:
  - full[wr_ptr] <= 1; wr_ptr toggles; cnt <= 0.
  - If in_last is low on that sample, the frame is still completed, frame_err pulses and err_cnt increments.
- Early in_last (in_last=1 with cnt<NPTS-1):
  - Frame is discarded: cnt <= 0, bank stays non-full, stale slots are overwritten by the next frame.
  - frame_err pulses the next cycle; err_cnt increments.
- err_cnt saturates at 2^ECW-1. frame_err asserts for exactly one cycle per error.
- Output side:
  - out_valid = full[rd_ptr], registered.
  - out_data = contents of bank rd_ptr; out_bitrev = latched mode of that bank.
  - out_data and out_bitrev are stable while out_valid=1 and not yet accepted.
  - On out_valid && out_ready: full[rd_ptr] <= 0; rd_ptr toggles.
- Latency and throughput:
  - Last sample accepted at edge T -> out_valid=1 after edge T (visible in cycle T+1).
  - With out_ready held high: continuous input, in_ready never drops, one frame out per NPTS cycles.
- Simultaneous events:
  - Completion of bank A and release of bank B on the same edge are both applied.
  - When the write bank fills while the other bank is still FULL, in_ready=0 until out_ready releases a bank.
  - in_ready returns to 1 on the cycle after the release edge. No sample is lost or duplicated.
- Wrap-around: the pointers are single bits and toggle freely; full flags alone prevent overrun.

Test Plan (NPTS=8, LOG2N=3, DW=34):
1. Reset, then send samples 0..7, in_last on sample 7, bitrev_en=0, out_ready=1 -> out_valid one cycle after sample 7 is accepted; slot k = k; out_bitrev=0; frame_err stays 0.
2. Same frame with bitrev_en=1 -> slots = {0,4,2,6,1,5,3,7} hold samples {0,1,2,3,4,5,6,7}, i.e. slot 4 = sample 1, slot 1 = sample 4; out_bitrev=1.
3. out_ready=0, stream three frames back-to-back -> frames 1 and 2 are buffered and in_ready=0 at the first sample of frame 3. Raise out_ready -> frames arrive in order 1, 2, 3 with no loss.
4. in_last on the 5th sample -> frame_err pulses once, err_cnt=1, no out_valid. The next 8-sample frame is output correctly.
5. 8 samples with in_last low throughout -> frame is output, frame_err=1 for one cycle, err_cnt increments.
6. Assert rst_n low mid-frame (after 3 samples) and with a FULL bank pending -> out_valid=0, err_cnt=0 immediately. The next 8 samples form a clean first frame.
